// File: rtl/magnetron_pkg.sv
// Shared types and helpers for the magnetron timer controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package magnetron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } mag_state_t;

    // Number of one-second ticks the done beep lasts.
    localparam int BEEP_TICKS = 3;

    // Limits a requested power step to the highest supported step.
    function automatic int clamp_power(input int level, input int max_level);
        return (level > max_level) ? max_level : level;
    endfunction

endpackage

// File: rtl/magnetron_timer_ctrl_tick_prescaler.sv
// One-second tick prescaler: counts 0..TICK_DIV-1 while run is high.
// Latency: tick is combinational from the count register (high at terminal count).
// Backpressure: run=0 freezes the count; clr zeroes it and has priority over run.
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count register: clear wins, otherwise advance and wrap while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // High while the count sits at its terminal value; the owner qualifies it
    // with run, so a held count at terminal never produces a second.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/magnetron_timer_ctrl.sv
// Magnetron cook controller: countdown timer, power duty cycle, pause/resume, door interlock.
// Latency: buttons act one clock after their rising edge; door_closed gates mag_on combinationally.
// Backpressure: none; build option MAGNETRON_DONE_BEEP_EN adds a 3-second beep output in DONE.
module magnetron_timer_ctrl
    import magnetron_pkg::*;
#(
    parameter int TIME_W     = 12,
    parameter int TICK_DIV   = 1000,
    parameter int PWR_LEVELS = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             stop,
    input  logic                             clear,
    input  logic                             door_closed,
    input  logic                             time_load,
    input  logic [TIME_W-1:0]                time_in,
    input  logic [$clog2(PWR_LEVELS+1)-1:0]  power_level,
    output logic                             mag_on,
    output logic                             busy,
    output logic                             done,
    output logic [TIME_W-1:0]                remaining
`ifdef MAGNETRON_DONE_BEEP_EN
    ,
    output logic                             beep
`endif
);

    localparam int PW = $clog2(PWR_LEVELS + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PWR_LEVELS - 1);

    mag_state_t        state_q, state_d;
    logic [TIME_W-1:0] rem_q, rem_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [PW-1:0]     pwr_q, pwr_d;
    logic              start_q, stop_q, clear_q;
    logic              start_p, stop_p, clear_p;
    logic              rem_one, at_last, presc_run, presc_clr, sec;

    assign start_p = start & ~start_q;
    assign stop_p  = stop  & ~stop_q;
    assign clear_p = clear & ~clear_q;
    assign rem_one = (rem_q == TIME_W'(1));

    // Button edge-detect flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            clear_q <= clear;
        end
    end

    // Prescaler control: run while cooking undisturbed; a door opening exactly
    // on the final tick still lets that tick land so DONE beats PAUSE.
    always_comb begin
        presc_run = 1'b0;
        if (state_q == COOK && !clear_p && !stop_p) begin
            presc_run = door_closed || (at_last && rem_one);
        end
`ifdef MAGNETRON_DONE_BEEP_EN
        if (state_q == DONE) begin
            presc_run = 1'b1;
        end
`endif
    end

    // IDLE keeps the prescaler at zero so every fresh cook starts on a second boundary.
    assign presc_clr = (state_q == IDLE);
    assign sec       = presc_run & at_last;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (presc_run),
        .clr   (presc_clr),
        .tick  (at_last)
    );

    // State, timer and power registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            phase_q <= '0;
            pwr_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
            pwr_q   <= pwr_d;
        end
    end

    // Next-state logic; within each state the order is clear > stop > door > start > tick.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        pwr_d   = pwr_q;
        unique case (state_q)
            IDLE: begin
                if (clear_p) begin
                    rem_d = '0;
                end else if (start_p && door_closed && rem_q != '0) begin
                    state_d = COOK;
                    phase_d = '0;
                    pwr_d   = PW'(clamp_power(int'(power_level), PWR_LEVELS));
                end else if (time_load) begin
                    rem_d = time_in;
                end
            end
            COOK: begin
                if (clear_p) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (stop_p) begin
                    state_d = PAUSE;
                end else begin
                    if (sec) begin
                        if (rem_q != '0) begin
                            rem_d = rem_q - 1'b1;
                        end
                        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
                        if (rem_one) begin
                            state_d = DONE;
                        end
                    end
                    if (!door_closed && !(sec && rem_one)) begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (clear_p || stop_p) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (start_p && door_closed) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (start_p || stop_p || clear_p || time_load) begin
                    state_d = IDLE;
                    if (time_load && !clear_p) begin
                        rem_d = time_in;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mag_on    = (state_q == COOK) && (phase_q < pwr_q) && door_closed;
    assign busy      = (state_q == COOK) || (state_q == PAUSE);
    assign done      = (state_q == DONE);
    assign remaining = rem_q;

`ifdef MAGNETRON_DONE_BEEP_EN
    logic [1:0] beep_cnt_q;

    // Seconds elapsed in DONE, saturating once the beep has run its course.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_cnt_q <= '0;
        end else if (state_q != DONE) begin
            beep_cnt_q <= '0;
        end else if (sec && beep_cnt_q < 2'(BEEP_TICKS)) begin
            beep_cnt_q <= beep_cnt_q + 1'b1;
        end
    end

    assign beep = (state_q == DONE) && (beep_cnt_q < 2'(BEEP_TICKS));
`endif

endmodule

// File: tb/tb_magnetron_timer_ctrl.sv
// Self-checking bench for magnetron_timer_ctrl (TICK_DIV=4, PWR_LEVELS=10).
// Latency: expected outputs are queued per cycle at the driving edge and compared by a monitor.
// Backpressure: n/a; every cycle produces one expected output set.
module tb_magnetron_timer_ctrl;

    localparam int TIME_W = 12;
    localparam int TD     = 4;
    localparam int PL     = 10;

    localparam int M_IDLE  = 0;
    localparam int M_COOK  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic              door_closed = 1'b1, time_load = 1'b0;
    logic [TIME_W-1:0] time_in = '0;
    logic [3:0]        power_level = '0;
    logic              mag_on, busy, done;
    logic [TIME_W-1:0] remaining;
`ifdef MAGNETRON_DONE_BEEP_EN
    logic              beep;
`endif

    typedef struct {
        int mag_on;
        int busy;
        int done;
        int beep;
        int remaining;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: cook progress is tracked as elapsed cooking cycles.
    int m_mode, m_rem, m_loaded, m_elapsed, m_pwr, m_dc;
    bit m_st_q, m_sp_q, m_cl_q;

    magnetron_timer_ctrl #(
        .TIME_W     (TIME_W),
        .TICK_DIV   (TD),
        .PWR_LEVELS (PL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .door_closed (door_closed),
        .time_load   (time_load),
        .time_in     (time_in),
        .power_level (power_level),
        .mag_on      (mag_on),
        .busy        (busy),
        .done        (done),
        .remaining   (remaining)
`ifdef MAGNETRON_DONE_BEEP_EN
        ,
        .beep        (beep)
`endif
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_rem = 0; m_loaded = 0; m_elapsed = 0; m_pwr = 0; m_dc = 0;
        m_st_q = 0; m_sp_q = 0; m_cl_q = 0;
    endtask

    // Computes this cycle's expected outputs from current inputs, then advances the model.
    task automatic model_cycle();
        exp_t e;
        bit stp, spp, clp, fin;
        int secs_done;
        if (!rst_n) begin
            model_reset();
            e.mag_on = 0; e.busy = 0; e.done = 0; e.beep = 0; e.remaining = 0;
            sb_q.push_back(e);
            return;
        end
        stp = start && !m_st_q;
        spp = stop  && !m_sp_q;
        clp = clear && !m_cl_q;
        secs_done = m_elapsed / TD;
        e.mag_on    = (m_mode == M_COOK && ((secs_done % PL) < m_pwr) && door_closed) ? 1 : 0;
        e.busy      = (m_mode == M_COOK || m_mode == M_PAUSE) ? 1 : 0;
        e.done      = (m_mode == M_DONE) ? 1 : 0;
        e.beep      = (m_mode == M_DONE && m_dc < 3 * TD) ? 1 : 0;
        e.remaining = e.busy ? (m_loaded - secs_done) : m_rem;
        sb_q.push_back(e);

        case (m_mode)
            M_IDLE: begin
                if (clp) m_rem = 0;
                else if (stp && door_closed && m_rem != 0) begin
                    m_mode = M_COOK; m_loaded = m_rem; m_elapsed = 0;
                    m_pwr = (power_level > PL) ? PL : int'(power_level);
                end else if (time_load) m_rem = int'(time_in);
            end
            M_COOK: begin
                fin = (m_elapsed % TD == TD - 1) && (m_loaded - secs_done == 1);
                if (clp) begin
                    m_mode = M_IDLE; m_rem = 0;
                end else if (spp) begin
                    m_mode = M_PAUSE;
                end else if (!door_closed) begin
                    if (fin) begin m_mode = M_DONE; m_rem = 0; m_dc = 0; end
                    else m_mode = M_PAUSE;
                end else begin
                    m_elapsed++;
                    if (m_elapsed / TD >= m_loaded) begin m_mode = M_DONE; m_rem = 0; m_dc = 0; end
                end
            end
            M_PAUSE: begin
                if (clp || spp) begin m_mode = M_IDLE; m_rem = 0; end
                else if (stp && door_closed) m_mode = M_COOK;
            end
            default: begin
                m_dc++;
                if (stp || spp || clp || time_load) begin
                    m_mode = M_IDLE;
                    m_rem = (time_load && !clp) ? int'(time_in) : 0;
                end
            end
        endcase
        m_st_q = start; m_sp_q = stop; m_cl_q = clear;
    endtask

    task automatic drive(input bit rs, input bit st, input bit sp, input bit cl, input bit dr,
                         input bit tl, input int tin, input int pl);
        @(negedge clk);
        rst_n = rs; start = st; stop = sp; clear = cl; door_closed = dr;
        time_load = tl; time_in = TIME_W'(tin); power_level = 4'(pl);
        model_cycle();
    endtask

    task automatic idle(input int n, input bit dr);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, dr, 0, 0, 0);
    endtask

    // Load a time, then press start on the next cycle with the given power.
    task automatic load_start(input int t, input int pl);
        drive(1, 0, 0, 0, 1, 1, t, pl);
        drive(1, 1, 0, 0, 1, 0, 0, pl);
    endtask

    // Scoreboard monitor: compares one queued expectation per cycle, away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp("mag_on", int'(mag_on), e.mag_on);
                cmp("busy", int'(busy), e.busy);
                cmp("done", int'(done), e.done);
                cmp("remaining", int'(remaining), e.remaining);
`ifdef MAGNETRON_DONE_BEEP_EN
                cmp("beep", int'(beep), e.beep);
`endif
            end
        end
    end

    initial begin
        int n, ones;
        model_reset();

        // Reset state.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, 0, 0);

        // Full power, 3 s: continuous mag_on, countdown, then DONE holds.
        load_start(3, 10);
        idle(16, 1);
        drive(1, 0, 0, 1, 1, 0, 0, 0);
        idle(2, 1);

        // Power 3 of 10: 12 of the first 40 cooking cycles have mag_on high.
        load_start(10, 3);
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1, 1);
            #2;
            ones += int'(mag_on);
        end
        cmp("duty_40", ones, 3 * TD);
        drive(1, 0, 0, 1, 1, 0, 0, 0);
        idle(2, 1);

        // Door opens mid-second, stays open 7 cycles, then close and restart.
        load_start(5, 10);
        idle(6, 1);
        idle(7, 0);
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        n = 14;
        for (int i = 0; i < 100; i++) begin
            idle(1, 1);
            #2;
            n++;
            if (done) break;
        end
        // Door-open cycles plus the restart press cycle extend the cook.
        cmp("pause_resume_cycles", n - 1, 5 * TD + 7 + 1);
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        idle(2, 1);

        // Stop pauses, second stop returns to IDLE, later start ignored.
        load_start(4, 10);
        idle(5, 1);
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        idle(2, 1);
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        idle(2, 1);
        drive(1, 1, 0, 0, 1, 0, 0, 10);
        idle(3, 1);
        #2;
        cmp("stop_stop_busy", int'(busy), 0);

        // Start with door open, and start with nothing loaded: both ignored.
        drive(1, 0, 0, 0, 1, 1, 2, 10);
        drive(1, 1, 0, 0, 0, 0, 0, 10);
        idle(3, 1);
        drive(1, 0, 0, 1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 0, 0, 10);
        idle(3, 1);

        // Start and clear together while cooking: clear wins.
        load_start(6, 10);
        idle(3, 1);
        drive(1, 1, 0, 1, 1, 0, 0, 10);
        idle(3, 1);

        // Door opens on the final tick: DONE rather than PAUSE.
        load_start(1, 10);
        idle(3, 1);
        idle(2, 0);
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        idle(2, 1);

        // Beep window: full 12 cycles, then an early clear at DONE cycle 5.
        load_start(1, 10);
        idle(4 + 14, 1);
        drive(1, 0, 0, 1, 1, 0, 0, 0);
        idle(1, 1);
        load_start(1, 10);
        idle(4 + 4, 1);
        drive(1, 0, 0, 1, 1, 0, 0, 0);
        idle(2, 1);

        // Asynchronous reset mid-cook drops mag_on at once.
        load_start(8, 10);
        idle(5, 1);
        @(posedge clk);
        #2;
        cmp("pre_reset_mag_on", int'(mag_on), 1);
        rst_n = 1'b0;
        #1;
        cmp("async_rst_mag_on", int'(mag_on), 0);
        cmp("async_rst_busy", int'(busy), 0);
        cmp("async_rst_remaining", int'(remaining), 0);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 1, 0, 0, 0);
        idle(2, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(1,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 19) != 0,
                  $urandom_range(0, 14) == 0,
                  int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 15)));
        end

        #3;
        cmp("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
